// File: rtl/inst_fetch_sequencer.sv
// Program-counter sequencer with a small prefetch FIFO between instruction memory and decode.
// Handles start, redirect-with-flush and halt-word detection.
module inst_fetch_sequencer #(
  parameter int          MEM_WORDS = 256,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     redirect_valid,
  input  logic [15:0]              redirect_addr,
  output logic [15:0]              inst_address,
  input  logic [31:0]              read_data,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_data,
  output logic [15:0]              inst_pc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     halted,
  output logic                     busy
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [15:0]       PC_MASK  = 16'(MEM_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      fifo_pc_q   [DEPTH];
  logic [31:0]      fifo_data_q [DEPTH];

  logic deq_s;
  logic fetch_ok_s;
  logic halt_hit_s;
  logic enq_s;

  // A full FIFO may still accept a fetch when the head leaves in the same cycle.
  always_comb begin
    deq_s      = (count_q != {CNT_W{1'b0}}) && inst_ready;
    fetch_ok_s = (state_q == ST_RUN) && !redirect_valid &&
                 ((count_q < FULL_CNT) || deq_s);
    halt_hit_s = fetch_ok_s && (read_data == HALT_WORD);
    enq_s      = fetch_ok_s && !halt_hit_s;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_addr & PC_MASK;
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
      state_d  = (state_q == ST_IDLE) ? ST_IDLE : ST_RUN;
    end else begin
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (enq_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        pc_d     = (pc_q + 16'd1) & PC_MASK;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      count_d = count_q + CNT_W'(enq_s) - CNT_W'(deq_s);
      case (state_q)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            state_d = ST_RUN;
            pc_d    = RESET_PC & PC_MASK;
          end else begin
            state_d = state_q;
          end
        end
        ST_RUN: begin
          if (halt_hit_s) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC & PC_MASK;
      rd_ptr_q <= {PTR_W{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      fifo_pc_q[wr_ptr_q]   <= pc_q;
      fifo_data_q[wr_ptr_q] <= read_data;
    end
  end

  assign inst_address = pc_q;
  assign inst_valid   = (count_q != {CNT_W{1'b0}});
  assign inst_data    = inst_valid ? fifo_data_q[rd_ptr_q] : 32'h0000_0000;
  assign inst_pc      = inst_valid ? fifo_pc_q[rd_ptr_q] : 16'h0000;
  assign fifo_count   = count_q;
  assign halted       = (state_q == ST_HALTED);
  assign busy         = (state_q == ST_RUN) || inst_valid;

endmodule

// File: tb/tb_inst_fetch_sequencer.sv
// Directed bench for inst_fetch_sequencer: a memory model feeds read_data and a
// scoreboard queue holds the {pc, instruction} pairs decode is expected to receive.
module tb_inst_fetch_sequencer;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic [15:0] inst_address;
  logic [31:0] read_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [15:0] inst_pc;
  logic [2:0]  fifo_count;
  logic        halted;
  logic        busy;

  logic [31:0] mem [256];
  logic [47:0] exp_q [$];
  int          compared   = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  assign read_data = (inst_address < 16'd256) ? mem[inst_address[7:0]] : 32'h0000_0000;

  inst_fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_address   (inst_address),
    .read_data      (read_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fifo_count     (fifo_count),
    .halted         (halted),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected stream from start_pc, stopping at a halt word as the fetcher should.
  function automatic void push_seq(input int start_pc, input int n);
    int p = start_pc;
    for (int k = 0; k < n; k++) begin
      if (mem[p] == HALT) break;
      exp_q.push_back({16'(p), mem[p]});
      p = (p + 1) % 256;
    end
  endfunction

  // One clock: any handshake seen at the negedge is checked against the scoreboard.
  task automatic tick();
    logic [47:0] e;
    @(negedge clk);
    if (inst_valid && inst_ready) begin
      chk("delivery_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("deliver_pc_data", {16'h0, inst_pc, inst_data}, {16'h0, e});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i * 3 + 1);
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0;
    redirect_addr = 16'h0000; inst_ready = 1'b0;
    ticks(2);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_data", 64'(inst_data), 64'd0);
    chk("rst_pc", 64'(inst_pc), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(inst_address), 64'd0);

    // Start, ready held high: 0,1,2 on consecutive cycles.
    reset = 1'b0; inst_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_entry_valid", 64'(inst_valid), 64'd0);
    chk("run_entry_busy", 64'(busy), 64'd1);
    push_seq(0, 3);
    tick();
    chk("first_valid", 64'(inst_valid), 64'd1);
    chk("first_pc", 64'(inst_pc), 64'd0);
    ticks(3);
    inst_ready = 1'b0;
    chk("start_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure from a clean redirect to 0.
    redirect_valid = 1'b1; redirect_addr = 16'h0000;
    tick();
    redirect_valid = 1'b0; exp_q.delete();
    chk("bp_flush_count", 64'(fifo_count), 64'd0);
    chk("bp_flush_valid", 64'(inst_valid), 64'd0);
    ticks(10);
    chk("bp_full_count", 64'(fifo_count), 64'd4);
    chk("bp_addr_hold", 64'(inst_address), 64'd4);
    chk("bp_head_pc", 64'(inst_pc), 64'd0);
    chk("bp_head_data", 64'(inst_data), 64'(mem[0]));
    push_seq(0, 5);
    inst_ready = 1'b1;
    ticks(5);
    inst_ready = 1'b0;
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_full_again", 64'(fifo_count), 64'd4);
    chk("bp_head_after", 64'(inst_pc), 64'd5);

    // Redirect flush with decode stalled.
    redirect_valid = 1'b1; redirect_addr = 16'h0040;
    tick();
    redirect_valid = 1'b0; exp_q.delete();
    chk("rd_flush_count", 64'(fifo_count), 64'd0);
    chk("rd_flush_valid", 64'(inst_valid), 64'd0);
    chk("rd_flush_data", 64'(inst_data), 64'd0);
    chk("rd_flush_pc", 64'(inst_pc), 64'd0);
    push_seq(16'h40, 1);
    tick();
    chk("rd_target_valid", 64'(inst_valid), 64'd1);
    chk("rd_target_pc", 64'(inst_pc), 64'h40);
    ticks(3);
    chk("rd_refill", 64'(fifo_count), 64'd4);

    // Redirect while the head is being accepted: head delivered, rest dropped.
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0080;
    tick();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    chk("rd_deq_delivered", 64'(exp_q.size()), 64'd0);
    chk("rd_deq_count", 64'(fifo_count), 64'd0);
    chk("rd_deq_valid", 64'(inst_valid), 64'd0);
    push_seq(16'h80, 2);
    inst_ready = 1'b1;
    ticks(3);
    inst_ready = 1'b0;
    chk("rd_deq_drained", 64'(exp_q.size()), 64'd0);

    // Halt word at address 5.
    mem[5] = HALT;
    redirect_valid = 1'b1; redirect_addr = 16'h0000;
    tick();
    redirect_valid = 1'b0; exp_q.delete();
    push_seq(0, 5);
    ticks(4);
    chk("halt_fill", 64'(fifo_count), 64'd4);
    inst_ready = 1'b1;
    ticks(2);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_busy_draining", 64'(busy), 64'd1);
    chk("halt_count", 64'(fifo_count), 64'd3);
    chk("halt_addr", 64'(inst_address), 64'd5);
    ticks(3);
    chk("halt_empty", 64'(fifo_count), 64'd0);
    chk("halt_busy_idle", 64'(busy), 64'd0);
    chk("halt_valid", 64'(inst_valid), 64'd0);
    ticks(3);
    chk("halt_addr_hold", 64'(inst_address), 64'd5);
    chk("halt_drained", 64'(exp_q.size()), 64'd0);

    // Restart from HALTED refetches from 0 and halts again.
    push_seq(0, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_halted", 64'(halted), 64'd0);
    ticks(8);
    chk("restart_halt_again", 64'(halted), 64'd1);
    chk("restart_addr", 64'(inst_address), 64'd5);
    chk("restart_drained", 64'(exp_q.size()), 64'd0);

    // Wrap-around; redirect address above MEM_WORDS is reduced modulo.
    mem[5] = 32'hA500_0010;
    inst_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 16'h01FE;
    tick();
    redirect_valid = 1'b0; exp_q.delete();
    chk("wrap_addr_mod", 64'(inst_address), 64'h00FE);
    chk("wrap_run", 64'(halted), 64'd0);
    push_seq(254, 4);
    inst_ready = 1'b1;
    ticks(5);
    inst_ready = 1'b0;
    chk("wrap_drained", 64'(exp_q.size()), 64'd0);
    chk("wrap_addr", 64'(inst_address), 64'd3);
    chk("wrap_head", 64'(inst_pc), 64'd2);
    chk("wrap_count", 64'(fifo_count), 64'd1);

    // Reset in the middle of a run.
    ticks(2);
    chk("mid_count", 64'(fifo_count), 64'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0; exp_q.delete();
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_valid", 64'(inst_valid), 64'd0);
    chk("mid_rst_halted", 64'(halted), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_addr", 64'(inst_address), 64'd0);
    ticks(3);
    chk("idle_no_fetch", 64'(inst_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Redirect in IDLE loads pc only; start then fetches from RESET_PC.
    redirect_valid = 1'b1; redirect_addr = 16'h0010;
    tick();
    redirect_valid = 1'b0;
    chk("idle_rd_addr", 64'(inst_address), 64'h10);
    chk("idle_rd_busy", 64'(busy), 64'd0);
    push_seq(0, 2);
    start = 1'b1; inst_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_start_addr", 64'(inst_address), 64'd0);
    ticks(3);
    inst_ready = 1'b0;
    chk("idle_start_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/inst_fetch_sequencer.md
Name: inst_fetch_sequencer

Overview:
- Program-counter sequencer and prefetch buffer in front of the 256-word instruction memory.
- Drives the memory's 16-bit word address and captures the combinational 32-bit read data into a DEPTH-entry FIFO.
- Delivers {pc, instruction} pairs to the decode stage over a valid/ready handshake.
- Handles start, branch/jump redirect with flush, and halt-word detection.

Parameters:
- MEM_WORDS, 256: instruction memory depth in words; PC wraps modulo this value (power of two).
- DEPTH, 4: prefetch FIFO entries (power of two, at least 2).
- RESET_PC, 16'h0000: PC loaded on reset and on start.
- HALT_WORD, 32'hFFFF_FFFF: instruction encoding that stops fetching.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin fetching from RESET_PC; honoured in IDLE or HALTED.
- redirect_valid  in  1  branch/jump taken; flush FIFO and load PC.
- redirect_addr  in  16  new PC; taken modulo MEM_WORDS.
- inst_address  out  16  word address to instruction memory; always equals the pc register.
- read_data  in  32  instruction memory data; combinational from inst_address, same cycle.
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  32  head instruction; 0 when FIFO empty.
- inst_pc  out  16  address of head instruction; 0 when FIFO empty.
- fifo_count  out  clog2(DEPTH)+1  occupied entries.
- halted  out  1  state is HALTED.
- busy  out  1  state is RUN or fifo_count != 0.

Behaviour:
- **Reset** (synchronous, takes priority over everything):
  - pc = RESET_PC; state = IDLE; FIFO empty; read/write pointers = 0.
  - inst_valid = 0, inst_data = 0, inst_pc = 0, fifo_count = 0, halted = 0, busy = 0.
  - Reset asserted mid-run discards all FIFO contents the next cycle.
- **States:** IDLE, RUN, HALTED.
  - IDLE -> RUN on start; pc <= RESET_PC.
  - RUN -> HALTED on halt detect.
  - HALTED -> RUN on start (pc <= RESET_PC) or on redirect_valid (pc <= redirect_addr).
  - Redirect in IDLE loads pc and stays in IDLE.
  - start while in RUN is ignored.
- **Dequeue:** occurs when inst_valid && inst_ready. The head advances next cycle.
- **Fetch eligibility:** state == RUN, no redirect, and (fifo_count < DEPTH or a dequeue occurs this cycle). Simultaneous enqueue and dequeue when full is legal; count stays at DEPTH.
- **Fetch, eligible and read_data != HALT_WORD:**
  - Enqueue {pc, read_data}.
  - pc <= (pc + 1) mod MEM_WORDS. Wrap: 255 -> 0 when MEM_WORDS = 256.
  - The entry becomes visible at the head on the next cycle; fetch-to-valid latency is 1 cycle.
- **Fetch, eligible and read_data == HALT_WORD:**
  - Halt word is not enqueued; pc holds (points at the halt word); state <= HALTED.
  - FIFO keeps draining normally.
- **Not eligible** (FIFO full, no dequeue): pc holds; nothing is enqueued.
- **Redirect** (highest priority after reset):
  - A dequeue in the same cycle completes; that instruction counts as delivered.
  - All remaining entries are flushed: fifo_count = 0 and inst_valid = 0 next cycle.
  - pc <= redirect_addr mod MEM_WORDS; no enqueue that cycle.
  - First post-redirect instruction is valid 2 cycles after redirect_valid is sampled.
  - Back-to-back redirects: the last one wins.
- **Output stability:** inst_data and inst_pc stay stable while inst_valid && !inst_ready.
- **Arithmetic:** pc is held in 16 bits; only the low clog2(MEM_WORDS) bits are nonzero; upper bits are driven 0.

Test Plan:
- **Reset then start:** mem[0..2] = A, B, C; start at cycle 1, inst_ready = 1 -> inst_pc 0, 1, 2 with data A, B, C on consecutive cycles; first inst_valid one cycle after RUN is entered.
- **Backpressure:** inst_ready = 0 for 10 cycles -> fifo_count saturates at 4, inst_address holds at 4, head stays at pc 0; release ready -> pcs 0..4 delivered in order with no loss or duplication.
- **Redirect flush:** FIFO holding pcs 3..6, redirect_valid with redirect_addr = 16'h0040 -> next cycle fifo_count = 0, inst_valid = 0; following cycle inst_pc = 0x40. Repeat with inst_ready = 1 in the redirect cycle -> pc 3 delivered, pcs 4..6 dropped.
- **Halt:** mem[5] = 32'hFFFF_FFFF -> pcs 0..4 delivered, pc 5 never appears; halted = 1; inst_address stays 5; busy drops to 0 once drained. start -> refetch from 0.
- **Wrap-around:** redirect to 254 -> inst_pc sequence 254, 255, 0, 1.
- **Reset mid-run:** reset pulsed while fifo_count = 3 -> next cycle fifo_count = 0, state IDLE, inst_address = 0, halted = 0, busy = 0.
